// File: rtl/cube_unscramble.sv
// cube_unscramble
//   Move-history recorder and inverse replayer. Each legal move applied to the cube while
//   idle is pushed onto a LIFO. On start the stack is replayed top-first. Every issued move
//   is the inverse of the stored one: the direction bit (bit 0) is flipped. Issued moves are
//   paced by a tick divider.
//
// Ports
//   clock_i       system clock, rising edge
//   reset_i       asynchronous, active-high; clears all state
//   rec_valid_i   rec_move_i was applied to the cube this cycle
//   rec_move_i    applied move code (0..11 legal, 12..15 ignored)
//   start_i       begin replay (level, sampled while idle)
//   clear_i       synchronous flush of stack and flags; aborts a replay
//   move_valid_o  one-cycle strobe: controller applies move_out_o
//   move_out_o    inverse move code, valid with move_valid_o
//   busy_o        high while waiting for a tick or issuing
//   done_o        one-cycle pulse when a replay finishes
//   count_o       entries currently stored (0..DEPTH)
//   overflow_o    sticky: a record was lost or overwritten
//
// Configuration
//   UNSCRAMBLE_RING_OVERWRITE_EN  defined: a push when full overwrites the oldest entry.
//                                 undefined: a push when full is dropped.
//                                 Either way the push sets overflow.

module cube_unscramble #(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned PTR_W    = 5,
    parameter int unsigned MOVE_W   = 4,
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              rec_valid_i,
    input  logic [MOVE_W-1:0] rec_move_i,
    input  logic              start_i,
    input  logic              clear_i,
    output logic              move_valid_o,
    output logic [MOVE_W-1:0] move_out_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [PTR_W:0]    count_o,
    output logic              overflow_o
);

    localparam int unsigned TickW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [TickW-1:0]  TickLast = TickW'(TICK_DIV - 1);
    localparam logic [TickW-1:0]  TickOne  = TickW'(1);
    localparam logic [PTR_W:0]    CntFull  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]    CntOne   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0]  PtrOne   = PTR_W'(1);
    localparam logic [MOVE_W-1:0] DirBit   = MOVE_W'(1);
    localparam logic [MOVE_W-1:0] NumLegal = MOVE_W'(12);

    typedef enum logic [1:0] {
        StIdle,
        StWaitTick,
        StIssue,
        StDone
    } state_e;

    state_e            state_q;
    logic [TickW-1:0]  tick_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W:0]    count_q;
    logic              overflow_q;
    logic              move_valid_q;
    logic [MOVE_W-1:0] move_out_q;
    logic              busy_q;
    logic              done_q;

    logic [MOVE_W-1:0] mem_q [DEPTH];

    logic              full;
    logic              push_req;
    logic              push_wr;
    logic [PTR_W-1:0]  top_ptr;

    always_comb begin
        full     = (count_q == CntFull);
        // Recording is only accepted while idle; clear wins over everything.
        push_req = (state_q == StIdle) && !clear_i && rec_valid_i && (rec_move_i < NumLegal);
`ifdef UNSCRAMBLE_RING_OVERWRITE_EN
        // Circular stack: writing at wr_ptr when full replaces the oldest entry.
        push_wr  = push_req;
`else
        push_wr  = push_req && !full;
`endif
        top_ptr  = wr_ptr_q - PtrOne;
    end

    // Stack storage; contents are meaningless while count_q is zero, so no reset is needed.
    always_ff @(posedge clock_i) begin
        if (push_wr) begin
            mem_q[wr_ptr_q] <= rec_move_i;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            tick_q       <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            move_valid_q <= 1'b0;
            move_out_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            move_valid_q <= 1'b0;
            move_out_q   <= '0;
            done_q       <= 1'b0;
            if (clear_i) begin
                state_q    <= StIdle;
                tick_q     <= '0;
                wr_ptr_q   <= '0;
                count_q    <= '0;
                overflow_q <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                if (push_wr) begin
                    wr_ptr_q <= wr_ptr_q + PtrOne;
                    if (!full) begin
                        count_q <= count_q + CntOne;
                    end
                end
                if (push_req && full) begin
                    overflow_q <= 1'b1;
                end

                unique case (state_q)
                    StIdle: begin
                        if (start_i) begin
                            tick_q <= '0;
                            // A push in this same cycle is part of the replay.
                            if ((count_q != '0) || push_wr) begin
                                state_q <= StWaitTick;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    StWaitTick: begin
                        if (tick_q == TickLast) begin
                            state_q      <= StIssue;
                            move_valid_q <= 1'b1;
                            move_out_q   <= mem_q[top_ptr] ^ DirBit;
                        end else begin
                            tick_q <= tick_q + TickOne;
                        end
                    end
                    StIssue: begin
                        wr_ptr_q <= top_ptr;
                        count_q  <= count_q - CntOne;
                        if (count_q == CntOne) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StWaitTick;
                            tick_q  <= '0;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign move_valid_o = move_valid_q;
    assign move_out_o   = move_out_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign count_o      = count_q;
    assign overflow_o   = overflow_q;

endmodule
